// File: rtl/letc_core_pkg.sv
// Shared LETC core types and constants used by the instruction-memory arbiter.
package letc_core_pkg;

  // Cycles from an accepted read to valid memory read data
  localparam int unsigned IMEM_READ_LATENCY = 2;

  // Widest supported instruction-memory word address
  localparam int unsigned IMEM_ADDR_W_MAX = 32;

  // One memory request as seen on the single memory port
  typedef struct packed {
    logic [IMEM_ADDR_W_MAX-1:0] addr;
    logic [31:0]                wdata;
  } imem_req_t;

endpackage

// File: rtl/letc_core_imem_arb_if.sv
// Fetch and loader handshake bundle between the core front end and the arbiter.
interface letc_core_imem_arb_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              i_fetch_valid;
  logic              o_fetch_ready;
  logic [ADDR_W-1:0] i_fetch_addr;
  logic              i_fetch_flush;
  logic              i_fetch_stall;
  logic              o_fetch_rvalid;
  logic [31:0]       o_fetch_rdata;

  logic              i_load_valid;
  logic              o_load_ready;
  logic [ADDR_W-1:0] i_load_addr;
  logic [31:0]       i_load_wdata;

  modport master (
    output i_fetch_valid, i_fetch_addr, i_fetch_flush, i_fetch_stall,
    output i_load_valid, i_load_addr, i_load_wdata,
    input  o_fetch_ready, o_fetch_rvalid, o_fetch_rdata, o_load_ready
  );

  modport slave (
    input  i_fetch_valid, i_fetch_addr, i_fetch_flush, i_fetch_stall,
    input  i_load_valid, i_load_addr, i_load_wdata,
    output o_fetch_ready, o_fetch_rvalid, o_fetch_rdata, o_load_ready
  );
endinterface

// File: rtl/letc_core_imem_resp_fifo.sv
// Two-entry response FIFO holding fetch read data until the consumer takes it.
module letc_core_imem_resp_fifo (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_push,
  input  logic [31:0] i_wdata,
  input  logic        i_pop,
  output logic        o_empty,
  output logic [31:0] o_rdata
);

  logic [31:0] r_mem [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;

  // Data storage carries no reset; only pointers and occupancy do
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointer and occupancy tracking; flush discards every entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: ;
      endcase
    end
  end

  assign o_empty = (r_count == 2'd0);
  assign o_rdata = r_mem[r_rptr];

endmodule

// File: rtl/letc_core_imem_arb.sv
// Instruction-memory arbiter: fetch-priority single-port access shared with the
// program loader, credit-limited read tracking and a two-entry response buffer.
module letc_core_imem_arb
  import letc_core_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  letc_core_imem_arb_if.slave  bus,
  output logic                 o_mem_en,
  output logic                 o_mem_we,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [31:0]          o_mem_wdata,
  input  logic [31:0]          i_mem_rdata
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  logic [1:0]                   r_credits;
  logic [IMEM_READ_LATENCY-1:0] r_pipe;
  logic [STARVE_W-1:0]          r_starve;

  logic                         w_starved;
  logic                         w_fetch_cap;
  logic                         w_fetch_req;
  logic                         w_fetch_ready;
  logic                         w_load_ready;
  logic                         w_fetch_win;
  logic                         w_load_win;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_rvalid;
  logic                         w_fifo_empty;
  logic [31:0]                  w_fifo_rdata;
  logic [1:0]                   w_credits_nxt;
  logic [IMEM_READ_LATENCY-1:0] w_pipe_nxt;
  imem_req_t                    w_req;

  // Arbitration: fetch wins unless idle/out of credits or the loader is starved.
  // During a flush every outstanding credit is being squashed, so fetch may issue.
  always_comb begin
    w_starved     = (r_starve == STARVE_W'(STARVE_MAX));
    w_fetch_cap   = i_rst_n && (bus.i_fetch_flush || (r_credits != 2'd2));
    w_fetch_req   = bus.i_fetch_valid && w_fetch_cap;
    w_fetch_ready = w_fetch_cap && !(bus.i_load_valid && w_starved);
    w_load_ready  = i_rst_n && (!w_fetch_req || w_starved);
    w_fetch_win   = bus.i_fetch_valid && w_fetch_ready;
    w_load_win    = bus.i_load_valid && w_load_ready;
  end

  // Winning request drives the memory port combinationally
  always_comb begin
    w_req = '0;
    if (w_load_win) begin
      w_req.addr  = IMEM_ADDR_W_MAX'(bus.i_load_addr);
      w_req.wdata = bus.i_load_wdata;
    end else if (w_fetch_win) begin
      w_req.addr  = IMEM_ADDR_W_MAX'(bus.i_fetch_addr);
    end
  end

  if (ADDR_W < IMEM_ADDR_W_MAX) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^w_req.addr[IMEM_ADDR_W_MAX-1:ADDR_W];
  end

  assign o_mem_en    = w_fetch_win || w_load_win;
  assign o_mem_we    = w_load_win;
  assign o_mem_addr  = w_req.addr[ADDR_W-1:0];
  assign o_mem_wdata = w_req.wdata;

  // Response side and next read-tracking state. A flush squashes the pipe and
  // FIFO, including data landing this cycle, but keeps a read issued alongside.
  always_comb begin
    w_push   = r_pipe[IMEM_READ_LATENCY-1] && !bus.i_fetch_flush;
    w_rvalid = !w_fifo_empty && !bus.i_fetch_flush;
    w_pop    = w_rvalid && !bus.i_fetch_stall;
    if (bus.i_fetch_flush) begin
      w_pipe_nxt    = '0;
      w_pipe_nxt[0] = w_fetch_win;
      w_credits_nxt = {1'b0, w_fetch_win};
    end else begin
      w_pipe_nxt    = {r_pipe[IMEM_READ_LATENCY-2:0], w_fetch_win};
      w_credits_nxt = r_credits + 2'(w_fetch_win) - 2'(w_pop);
    end
  end

  // Read-tracking registers: credits and in-flight valid pipe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_credits <= '0;
      r_pipe    <= '0;
    end else begin
      r_credits <= w_credits_nxt;
      r_pipe    <= w_pipe_nxt;
    end
  end

  // Starvation counter: counts contested fetch wins, cleared by a loader grant
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= '0;
    end else if (w_load_win) begin
      r_starve <= '0;
    end else if (w_fetch_win && bus.i_load_valid && !w_starved) begin
      r_starve <= r_starve + STARVE_W'(1);
    end
  end

  letc_core_imem_resp_fifo u_resp_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (bus.i_fetch_flush),
    .i_push  (w_push),
    .i_wdata (i_mem_rdata),
    .i_pop   (w_pop),
    .o_empty (w_fifo_empty),
    .o_rdata (w_fifo_rdata)
  );

  assign bus.o_fetch_ready  = w_fetch_ready;
  assign bus.o_load_ready   = w_load_ready;
  assign bus.o_fetch_rvalid = w_rvalid;
  assign bus.o_fetch_rdata  = w_fifo_rdata;

endmodule

// File: tb/tb_letc_core_imem_arb.sv
// Scoreboard bench for letc_core_imem_arb: directed scenarios plus random traffic
// checked against a queue-based reference of outstanding fetch reads.
module tb_letc_core_imem_arb;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned STARVE_MAX = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  letc_core_imem_arb_if #(.ADDR_W(ADDR_W)) bus ();

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  letc_core_imem_arb #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  // Memory environment: word n holds 0x100+n until written; read data two cycles out
  logic [31:0] env_mem [int];
  logic [31:0] rd1 = '0;
  logic [31:0] rd2 = '0;
  always @(posedge clk) begin
    if (mem_en && mem_we) env_mem[int'(mem_addr)] = mem_wdata;
    if (mem_en && !mem_we)
      rd1 <= env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : 32'h100 + 32'(mem_addr);
    else
      rd1 <= 32'hBAD0_BAD0;
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  int unsigned ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, ecount);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ecount);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [31:0] data;
    int unsigned acc;
  } exp_t;
  exp_t        q[$];
  logic [31:0] ref_mem [int];
  int unsigned run = 0;
  logic        starve_mode = 1'b0;
  logic        have_lg = 1'b0;
  int unsigned last_lg = 0;

  function automatic logic [31:0] ref_read(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h100 + 32'(a);
  endfunction

  // Monitor/scoreboard: every cycle compares outputs against the reference,
  // pops responses the consumer takes and records what the coming edge accepts
  initial begin
    int unsigned n_out;
    logic        exp_rv, exp_fr, exp_lr, fetch_req, starved, fx, lx;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk1("rst_fetch_ready", bus.o_fetch_ready, 1'b0);
        chk1("rst_load_ready", bus.o_load_ready, 1'b0);
        chk1("rst_rvalid", bus.o_fetch_rvalid, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        q.delete();
        run = 0;
        have_lg = 1'b0;
      end else begin
        n_out  = q.size();
        exp_rv = !bus.i_fetch_flush && (n_out > 0) && (ecount >= q[0].acc + 2);
        chk1("rvalid", bus.o_fetch_rvalid, exp_rv);
        if (exp_rv && bus.o_fetch_rvalid) chk32("rdata", bus.o_fetch_rdata, q[0].data);
        chk1("push_into_full_fifo", dut.w_push && (dut.u_resp_fifo.r_count == 2'd2), 1'b0);

        starved   = (run == STARVE_MAX);
        fetch_req = bus.i_fetch_valid && (bus.i_fetch_flush || n_out < 2);
        exp_fr    = (bus.i_fetch_flush || n_out < 2) && !(bus.i_load_valid && starved);
        exp_lr    = !fetch_req || starved;
        chk1("fetch_ready", bus.o_fetch_ready, exp_fr);
        chk1("load_ready", bus.o_load_ready, exp_lr);

        if (exp_rv && !bus.i_fetch_stall) void'(q.pop_front());
        if (bus.i_fetch_flush) q.delete();

        fx = bus.i_fetch_valid && exp_fr;
        lx = bus.i_load_valid && exp_lr;
        chk1("mem_en", mem_en, fx || lx);
        if (lx) begin
          chk1("load_mem_we", mem_we, 1'b1);
          chk32("load_mem_addr", 32'(mem_addr), 32'(bus.i_load_addr));
          chk32("load_mem_wdata", mem_wdata, bus.i_load_wdata);
          ref_mem[int'(bus.i_load_addr)] = bus.i_load_wdata;
          run = 0;
        end else if (fx) begin
          chk1("fetch_mem_we", mem_we, 1'b0);
          chk32("fetch_mem_addr", 32'(mem_addr), 32'(bus.i_fetch_addr));
          q.push_back('{data: ref_read(bus.i_fetch_addr), acc: ecount + 1});
          if (bus.i_load_valid) run++;
        end

        if (starve_mode && bus.i_load_valid && bus.o_load_ready) begin
          if (have_lg) chk32("load_grant_period", ecount - last_lg, STARVE_MAX + 1);
          have_lg = 1'b1;
          last_lg = ecount;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_seq(input logic [ADDR_W-1:0] a);
    int unsigned n = 0;
    bus.i_fetch_valid = 1'b1;
    bus.i_fetch_addr  = a;
    @(negedge clk);
    while (!bus.o_fetch_ready && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk1("fetch_accept_in_time", n < 30, 1'b1);
    cyc();
    bus.i_fetch_valid = 1'b0;
  endtask

  task automatic load_seq(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    int unsigned n = 0;
    bus.i_load_valid = 1'b1;
    bus.i_load_addr  = a;
    bus.i_load_wdata = d;
    @(negedge clk);
    while (!bus.o_load_ready && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk1("load_accept_in_time", n < 30, 1'b1);
    cyc();
    bus.i_load_valid = 1'b0;
  endtask

  // Stimulus
  initial begin
    bus.i_fetch_valid = 1'b0;
    bus.i_fetch_addr  = '0;
    bus.i_fetch_flush = 1'b0;
    bus.i_fetch_stall = 1'b0;
    bus.i_load_valid  = 1'b0;
    bus.i_load_addr   = '0;
    bus.i_load_wdata  = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    // Back-to-back fetches of words 0, 1, 2
    fetch_seq(10'd0);
    fetch_seq(10'd1);
    fetch_seq(10'd2);
    repeat (6) cyc();

    // Stall holds 0x105 while credits run out
    bus.i_fetch_stall = 1'b1;
    fetch_seq(10'd5);
    fetch_seq(10'd6);
    bus.i_fetch_valid = 1'b1;
    bus.i_fetch_addr  = 10'd7;
    repeat (4) cyc();
    bus.i_fetch_stall = 1'b0;
    fetch_seq(10'd7);
    repeat (6) cyc();

    // Flush together with a new fetch at 9
    fetch_seq(10'h20);
    fetch_seq(10'h21);
    bus.i_fetch_flush = 1'b1;
    fetch_seq(10'd9);
    bus.i_fetch_flush = 1'b0;
    repeat (6) cyc();

    // Loader write followed by fetch of the same word
    load_seq(10'd3, 32'h0000_DEAD);
    fetch_seq(10'd3);
    repeat (6) cyc();

    // Continuous contention: loader must be granted every 9th cycle
    starve_mode       = 1'b1;
    bus.i_fetch_flush = 1'b1;
    bus.i_fetch_valid = 1'b1;
    bus.i_fetch_addr  = 10'd4;
    bus.i_load_valid  = 1'b1;
    bus.i_load_addr   = 10'h3FF;
    bus.i_load_wdata  = 32'h1234_5678;
    repeat (40) cyc();
    starve_mode       = 1'b0;
    bus.i_fetch_flush = 1'b0;
    bus.i_fetch_valid = 1'b0;
    bus.i_load_valid  = 1'b0;
    repeat (4) cyc();

    // Reset with two reads in flight
    fetch_seq(10'h10);
    fetch_seq(10'h11);
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (6) cyc();
    fetch_seq(10'h12);
    repeat (6) cyc();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      bus.i_fetch_valid = ($urandom_range(0, 9) < 7);
      bus.i_fetch_addr  = ADDR_W'($urandom_range(0, 15));
      bus.i_load_valid  = ($urandom_range(0, 9) < 3);
      bus.i_load_addr   = ADDR_W'($urandom_range(0, 15));
      bus.i_load_wdata  = $urandom;
      bus.i_fetch_flush = ($urandom_range(0, 15) == 0);
      bus.i_fetch_stall = ($urandom_range(0, 9) < 3);
      cyc();
    end
    bus.i_fetch_valid = 1'b0;
    bus.i_load_valid  = 1'b0;
    bus.i_fetch_flush = 1'b0;
    bus.i_fetch_stall = 1'b0;
    repeat (10) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
